// File: rtl/port_b_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// port_b_arbiter_pkg
// Shared widths and encodings for the Memory port B arbiter.
//   ADDR_W  : word address width of Memory port B
//   DATA_W  : data width of Memory port B
//   state_t : arbiter FSM states (IDLE: grant decision, RESP: aux completion)
//   owner_t : which requester was granted the port in the previous cycle
// ---------------------------------------------------------------------------
package port_b_arbiter_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_AUX  = 2'd2
    } owner_t;

endpackage

// File: rtl/port_b_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// port_b_arbiter_starve_counter
// Saturating wait counter for the aux requester.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the count to zero (aux granted or aux not requesting)
//   inc        : count one more waiting cycle (saturates at LIMIT)
//   at_limit   : current count equals LIMIT
//   reach      : count will equal LIMIT after this edge
// ---------------------------------------------------------------------------
module port_b_arbiter_starve_counter #(
    parameter int LIMIT = 64,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_limit,
    output logic reach
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (inc && (cnt < CNT_W'(LIMIT))) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign at_limit = (cnt == CNT_W'(LIMIT));
    assign reach    = (cnt_next == CNT_W'(LIMIT));

endmodule

// File: rtl/port_b_arbiter.sv
// ---------------------------------------------------------------------------
// port_b_arbiter
// Shares Memory port B (1-cycle registered read) between the display pixel
// fetcher (strict priority, fixed latency, no handshake) and an aux master
// (req/ack handshake, read or write).
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   disp_req/disp_addr      : display read request and address
//   disp_valid/disp_data    : display read data, one cycle after grant
//   disp_miss               : display read dropped for a forced aux slot
//   aux_req/aux_we/aux_addr/aux_wdata : aux request, held until aux_ack
//   aux_ack/aux_rdata       : one-cycle completion pulse and read data
//   aux_starved             : sticky, aux waited STARVE_LIMIT cycles
//   mem_addr/mem_we/mem_din/mem_dout : Memory port B pins
// ---------------------------------------------------------------------------
module port_b_arbiter
    import port_b_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 64,
    parameter int FORCE_SLOT   = 1,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_miss,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_starved,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t state, state_next;
    owner_t owner, owner_next;
    logic   starved;
    logic   miss_r;
    logic   grant_disp, grant_aux, force_slot;
    logic   at_limit, reach;
    logic   cnt_clear, cnt_inc;

    // Grant decision. In RESP the port belongs to the display and aux_req is
    // ignored (the aux master is still seeing its ack this cycle).
    always_comb begin
        grant_disp = 1'b0;
        grant_aux  = 1'b0;
        force_slot = 1'b0;
        state_next = ST_IDLE;
        owner_next = OWN_NONE;
        if (!reset) begin
            if (state == ST_IDLE) begin
                force_slot = (FORCE_SLOT != 0) && aux_req && at_limit;
                grant_aux  = aux_req && (!disp_req || force_slot);
                grant_disp = disp_req && !grant_aux;
            end else begin
                grant_disp = disp_req;
            end
            if (grant_aux) begin
                state_next = ST_RESP;
                owner_next = OWN_AUX;
            end else if (grant_disp) begin
                owner_next = OWN_DISP;
            end
        end
    end

    // Memory port B mux: idle and reset cycles drive zeros.
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_din  = '0;
        if (grant_aux) begin
            mem_addr = aux_addr;
            mem_we   = aux_we;
            mem_din  = aux_wdata;
        end else if (grant_disp) begin
            mem_addr = disp_addr;
        end
    end

    // Waiting only counts in IDLE; RESP holds the count.
    assign cnt_clear = grant_aux || !aux_req;
    assign cnt_inc   = (state == ST_IDLE) && aux_req && !grant_aux;

    port_b_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .at_limit (at_limit),
        .reach    (reach)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            starved <= 1'b0;
            miss_r  <= 1'b0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            starved <= starved | reach;
            miss_r  <= disp_req && grant_aux;
        end
    end

    // Response side: memory data arrives one cycle after the grant, so the
    // registered owner tells who the current mem_dout belongs to.
    assign disp_valid  = (owner == OWN_DISP);
    assign disp_data   = mem_dout;
    assign disp_miss   = miss_r;
    assign aux_ack     = (state == ST_RESP);
    assign aux_rdata   = mem_dout;
    assign aux_starved = starved;

endmodule
